// File: rtl/fwd_source_pipe.sv
// rtl/fwd_source_pipe.sv - EX_MEM / MEM_WB / WB_ID result stages feeding operand forwarding
//
// Holds the three post-EX tag/result stages that the forwarding mux reads.
// It also detects the load-use hazard against the instruction now in EX,
// inserts the single bubble that resolves it, and counts those bubbles.
module fwd_source_pipe #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            ex_valid,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_alures,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [4:0]      id_ex_rs1,
  input  logic [4:0]      id_ex_rs2,
  input  logic            stall,
  input  logic            flush,
  output logic            EX_MEM_regwrite,
  output logic            EX_MEM_memread,
  output logic [4:0]      EX_MEM_rd,
  output logic [XLEN-1:0] alures,
  output logic            MEM_WB_regwrite,
  output logic [4:0]      MEM_WB_rd,
  output logic [XLEN-1:0] memres,
  output logic            WB_ID_regwrite,
  output logic [4:0]      WB_ID_rd,
  output logic [XLEN-1:0] wbres,
  output logic            load_use_stall,
  output logic [CNTW-1:0] lu_count
);

  localparam logic [CNTW-1:0] LU_MAX = '1;
  localparam logic [CNTW-1:0] LU_ONE = CNTW'(1);

  // EX_MEM stage
  logic            ex_mem_regwrite_q, ex_mem_regwrite_d;
  logic            ex_mem_memread_q,  ex_mem_memread_d;
  logic [4:0]      ex_mem_rd_q,       ex_mem_rd_d;
  logic [XLEN-1:0] ex_mem_alures_q,   ex_mem_alures_d;

  // MEM_WB stage
  logic            mem_wb_regwrite_q, mem_wb_regwrite_d;
  logic [4:0]      mem_wb_rd_q,       mem_wb_rd_d;
  logic [XLEN-1:0] mem_wb_res_q,      mem_wb_res_d;

  // WB_ID stage
  logic            wb_id_regwrite_q,  wb_id_regwrite_d;
  logic [4:0]      wb_id_rd_q,        wb_id_rd_d;
  logic [XLEN-1:0] wb_id_res_q,       wb_id_res_d;

  // Load-use bubble counter
  logic [CNTW-1:0] lu_count_q,        lu_count_d;

  logic cap_regwrite;
  logic cap_memread;
  logic hazard;
  logic bubble;

  // Qualify the EX-stage instruction; x0 is never a real destination
  always_comb begin
    cap_regwrite = ex_valid & ex_regwrite & (ex_rd != 5'd0);
    cap_memread  = ex_valid & ex_memread  & (ex_rd != 5'd0);
  end

  // Load in EX_MEM whose result the EX instruction needs: data not ready yet
  always_comb begin
    hazard = ex_mem_regwrite_q & ex_mem_memread_q &
             ((ex_mem_rd_q == id_ex_rs1) | (ex_mem_rd_q == id_ex_rs2));
  end

  // A flush or a hazard replaces the EX capture with an empty slot
  always_comb begin
    bubble = flush | hazard;
  end

  // EX_MEM next state: hold on stall, bubble on flush/hazard, else capture EX
  always_comb begin
    ex_mem_regwrite_d = ex_mem_regwrite_q;
    ex_mem_memread_d  = ex_mem_memread_q;
    ex_mem_rd_d       = ex_mem_rd_q;
    ex_mem_alures_d   = ex_mem_alures_q;
    if (!stall) begin
      if (bubble) begin
        ex_mem_regwrite_d = 1'b0;
        ex_mem_memread_d  = 1'b0;
        ex_mem_rd_d       = 5'd0;
        ex_mem_alures_d   = '0;
      end else begin
        ex_mem_regwrite_d = cap_regwrite;
        ex_mem_memread_d  = cap_memread;
        ex_mem_rd_d       = ex_rd;
        ex_mem_alures_d   = ex_alures;
      end
    end
  end

  // MEM_WB next state: loads take memory data, everything else the ALU result
  always_comb begin
    mem_wb_regwrite_d = mem_wb_regwrite_q;
    mem_wb_rd_d       = mem_wb_rd_q;
    mem_wb_res_d      = mem_wb_res_q;
    if (!stall) begin
      mem_wb_regwrite_d = ex_mem_regwrite_q;
      mem_wb_rd_d       = ex_mem_rd_q;
      mem_wb_res_d      = ex_mem_memread_q ? mem_rdata : ex_mem_alures_q;
    end
  end

  // WB_ID next state: plain copy of MEM_WB, so the writeback value stays forwardable
  always_comb begin
    wb_id_regwrite_d = wb_id_regwrite_q;
    wb_id_rd_d       = wb_id_rd_q;
    wb_id_res_d      = wb_id_res_q;
    if (!stall) begin
      wb_id_regwrite_d = mem_wb_regwrite_q;
      wb_id_rd_d       = mem_wb_rd_q;
      wb_id_res_d      = mem_wb_res_q;
    end
  end

  // Count bubbles caused by hazards only; flush-caused bubbles do not count
  always_comb begin
    lu_count_d = lu_count_q;
    if (!stall && !flush && hazard && (lu_count_q != LU_MAX)) begin
      lu_count_d = lu_count_q + LU_ONE;
    end
  end

  // Stage and counter registers, cleared asynchronously
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      ex_mem_regwrite_q <= 1'b0;
      ex_mem_memread_q  <= 1'b0;
      ex_mem_rd_q       <= 5'd0;
      ex_mem_alures_q   <= '0;
      mem_wb_regwrite_q <= 1'b0;
      mem_wb_rd_q       <= 5'd0;
      mem_wb_res_q      <= '0;
      wb_id_regwrite_q  <= 1'b0;
      wb_id_rd_q        <= 5'd0;
      wb_id_res_q       <= '0;
      lu_count_q        <= '0;
    end else begin
      ex_mem_regwrite_q <= ex_mem_regwrite_d;
      ex_mem_memread_q  <= ex_mem_memread_d;
      ex_mem_rd_q       <= ex_mem_rd_d;
      ex_mem_alures_q   <= ex_mem_alures_d;
      mem_wb_regwrite_q <= mem_wb_regwrite_d;
      mem_wb_rd_q       <= mem_wb_rd_d;
      mem_wb_res_q      <= mem_wb_res_d;
      wb_id_regwrite_q  <= wb_id_regwrite_d;
      wb_id_rd_q        <= wb_id_rd_d;
      wb_id_res_q       <= wb_id_res_d;
      lu_count_q        <= lu_count_d;
    end
  end

  assign EX_MEM_regwrite = ex_mem_regwrite_q;
  assign EX_MEM_memread  = ex_mem_memread_q;
  assign EX_MEM_rd       = ex_mem_rd_q;
  assign alures          = ex_mem_alures_q;
  assign MEM_WB_regwrite = mem_wb_regwrite_q;
  assign MEM_WB_rd       = mem_wb_rd_q;
  assign memres          = mem_wb_res_q;
  assign WB_ID_regwrite  = wb_id_regwrite_q;
  assign WB_ID_rd        = wb_id_rd_q;
  assign wbres           = wb_id_res_q;
  assign load_use_stall  = hazard;
  assign lu_count        = lu_count_q;

endmodule
